// File: rtl/apb_stdout_pkg.sv
// Shared constants and types for the APB stdout arbiter: address field layout,
// FSM states and the latched request record.
package apb_stdout_pkg;

   localparam int unsigned CL_SHIFT   = 7;
   localparam int unsigned CORE_SHIFT = 3;
   localparam int unsigned IDX_W      = 4;
   localparam int unsigned CHAR_W     = 8;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess
   } state_e;

   typedef struct packed {
      logic [IDX_W-1:0]  cl;
      logic [IDX_W-1:0]  core;
      logic [CHAR_W-1:0] ch;
   } req_t;

endpackage

// File: rtl/apb_stdout_rr_pick.sv
// Round-robin picker: first valid requester at or after the pointer, wrapping.
// Purely combinational; returns a one-hot grant, its index and an any-valid flag.
module apb_stdout_rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic [N_REQ-1:0] valid_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      any_o   = 1'b0;
      // Walk offsets from farthest to nearest so the nearest valid wins.
      for (int unsigned off = N_REQ; off > 0; off--) begin
         int unsigned j;
         j = (32'(ptr_i) + off - 1) % N_REQ;
         if (valid_i[j]) begin
            grant_o    = '0;
            grant_o[j] = 1'b1;
            idx_o      = PTR_W'(j);
            any_o      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_stdout_arbiter.sv
// Round-robin arbiter sharing one APB stdout slave among N_REQ character
// producers; each accepted character becomes one APB write.
module apb_stdout_arbiter
   import apb_stdout_pkg::*;
#(
   parameter int unsigned            N_REQ      = 4,
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [N_REQ-1:0]          req_valid_i,
   output logic [N_REQ-1:0]          req_ready_o,
   input  logic [N_REQ*IDX_W-1:0]    req_cl_i,
   input  logic [N_REQ*IDX_W-1:0]    req_core_i,
   input  logic [N_REQ*CHAR_W-1:0]   req_char_i,
   output logic                      busy_o,
   output logic [15:0]               err_cnt_o,
   output logic                      apb_psel_o,
   output logic                      apb_penable_o,
   output logic                      apb_pwrite_o,
   output logic [ADDR_WIDTH-1:0]     apb_paddr_o,
   output logic [DATA_WIDTH-1:0]     apb_pwdata_o,
   input  logic                      apb_pready_i,
   input  logic                      apb_pslverr_i
);

   localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   state_e                state_q, state_d;
   logic [PtrW-1:0]       ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic [15:0]           err_cnt_q, err_cnt_d;

   logic [N_REQ-1:0]      grant;
   logic [PtrW-1:0]       grant_idx;
   logic                  grant_any;
   logic                  can_grant;
   req_t                  req_sel;

   apb_stdout_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PtrW)
   ) u_rr_pick (
      .valid_i (req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (grant_idx),
      .any_o   (grant_any)
   );

   assign req_sel.cl   = req_cl_i[32'(grant_idx)*IDX_W +: IDX_W];
   assign req_sel.core = req_core_i[32'(grant_idx)*IDX_W +: IDX_W];
   assign req_sel.ch   = req_char_i[32'(grant_idx)*CHAR_W +: CHAR_W];

   assign can_grant   = (state_q == StIdle) || ((state_q == StAccess) && apb_pready_i);
   // Held off during reset so no character is accepted and then lost.
   assign req_ready_o = (rst_ni && can_grant) ? grant : '0;

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      err_cnt_d = err_cnt_q;
      case (state_q)
         StIdle:   state_d = StIdle;
         StSetup:  state_d = StAccess;
         StAccess: begin
            if (apb_pready_i) begin
               state_d = StIdle;
               if (apb_pslverr_i && (err_cnt_q != 16'hFFFF)) begin
                  err_cnt_d = err_cnt_q + 16'd1;
               end
            end
         end
         default:  state_d = StIdle;
      endcase
      if (can_grant && grant_any) begin
         state_d  = StSetup;
         ptr_d    = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PtrW'(1);
         paddr_d  = BASE_ADDR
                  | (ADDR_WIDTH'(req_sel.cl) << CL_SHIFT)
                  | (ADDR_WIDTH'(req_sel.core) << CORE_SHIFT);
         pwdata_d = DATA_WIDTH'(req_sel.ch);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         ptr_q     <= '0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign apb_psel_o    = (state_q != StIdle);
   assign apb_penable_o = (state_q == StAccess);
   assign apb_pwrite_o  = (state_q != StIdle);
   assign apb_paddr_o   = paddr_q;
   assign apb_pwdata_o  = pwdata_q;
   assign busy_o        = (state_q != StIdle);
   assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_apb_stdout_arbiter.sv
// Bench for apb_stdout_arbiter: a directed vector table, hand-written reset and
// saturation sequences, then randomized traffic against a transaction-level model.
module tb_apb_stdout_arbiter;

   localparam int          N    = 4;
   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] A0   = BASE | 32'h090;
   localparam logic [31:0] A1   = BASE | 32'h118;
   localparam logic [31:0] A2   = BASE | 32'h1A0;
   localparam logic [31:0] A3   = BASE | 32'h228;

   logic          clk = 1'b0;
   logic          rst_ni;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [15:0]   req_cl;
   logic [15:0]   req_core;
   logic [31:0]   req_char;
   logic          busy;
   logic [15:0]   err_cnt;
   logic          psel, penable, pwrite;
   logic [31:0]   paddr, pwdata;
   logic          pready, pslverr;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   apb_stdout_arbiter #(
      .N_REQ      (N),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .BASE_ADDR  (BASE)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid),
      .req_ready_o   (req_ready),
      .req_cl_i      (req_cl),
      .req_core_i    (req_core),
      .req_char_i    (req_char),
      .busy_o        (busy),
      .err_cnt_o     (err_cnt),
      .apb_psel_o    (psel),
      .apb_penable_o (penable),
      .apb_pwrite_o  (pwrite),
      .apb_paddr_o   (paddr),
      .apb_pwdata_o  (pwdata),
      .apb_pready_i  (pready),
      .apb_pslverr_i (pslverr)
   );

   typedef struct {
      logic [3:0]  valid;
      logic        rdy;
      logic        err;
      logic [3:0]  exp_ready;
      logic        exp_psel;
      logic        exp_pen;
      logic [31:0] exp_paddr;
      logic [31:0] exp_pwdata;
      logic [15:0] exp_err;
   } vec_t;

   vec_t tbl [27];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: one outstanding transfer record plus a rotating priority.
   logic        m_act, m_acc;
   logic [31:0] m_paddr, m_pwdata;
   int          m_ptr;
   int          m_err;

   function automatic int pick(input logic [3:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_act = 1'b0; m_acc = 1'b0; m_paddr = '0; m_pwdata = '0; m_ptr = 0; m_err = 0;
   endtask

   initial begin
      rst_ni    = 1'b0;
      req_valid = 4'b1111;
      pready    = 1'b1;
      pslverr   = 1'b0;
      req_cl    = {4'd4, 4'd3, 4'd2, 4'd1};
      req_core  = {4'd5, 4'd4, 4'd3, 4'd2};
      req_char  = {8'h44, 8'h43, 8'h42, 8'h41};
      step();
      step();
      chk("rst.ready", 32'(req_ready), 32'h0);
      chk("rst.psel", 32'(psel), 32'h0);
      chk("rst.penable", 32'(penable), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      chk("rst.paddr", paddr, 32'h0);
      chk("rst.err", 32'(err_cnt), 32'h0);

      //         valid   rdy   err   ready   psel  pen   paddr pwdata    err
      tbl[0]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h00, 16'd0};
      tbl[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A0,    32'h41, 16'd0};
      tbl[2]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, A0,    32'h41, 16'd0};
      tbl[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, A0,    32'h41, 16'd0};
      tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, A0,    32'h41, 16'd0};
      tbl[5]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A1,    32'h42, 16'd0};
      tbl[6]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, A1,    32'h42, 16'd0};
      tbl[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A2,    32'h43, 16'd0};
      tbl[8]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, A2,    32'h43, 16'd0};
      tbl[9]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A3,    32'h44, 16'd0};
      tbl[10] = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, A3,    32'h44, 16'd0};
      tbl[11] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A0,    32'h41, 16'd0};
      tbl[12] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, A0,    32'h41, 16'd0};
      tbl[13] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, A0,    32'h41, 16'd0};
      tbl[14] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, A0,    32'h41, 16'd0};
      tbl[15] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, A0,    32'h41, 16'd0};
      tbl[16] = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, A0,    32'h41, 16'd1};
      tbl[17] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A1,    32'h42, 16'd1};
      tbl[18] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, A1,    32'h42, 16'd1};
      tbl[19] = '{4'b0110, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, A1,    32'h42, 16'd2};
      tbl[20] = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A2,    32'h43, 16'd2};
      tbl[21] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, A2,    32'h43, 16'd2};
      tbl[22] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, A2,    32'h43, 16'd3};
      tbl[23] = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, A2,    32'h43, 16'd3};
      tbl[24] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, A0,    32'h41, 16'd3};
      tbl[25] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, A0,    32'h41, 16'd3};
      tbl[26] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, A0,    32'h41, 16'd3};

      rst_ni = 1'b1;
      for (int i = 0; i < 27; i++) begin
         req_valid = tbl[i].valid;
         pready    = tbl[i].rdy;
         pslverr   = tbl[i].err;
         @(negedge clk);
         chk($sformatf("v%0d.ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
         chk($sformatf("v%0d.psel", i), 32'(psel), 32'(tbl[i].exp_psel));
         chk($sformatf("v%0d.penable", i), 32'(penable), 32'(tbl[i].exp_pen));
         chk($sformatf("v%0d.pwrite", i), 32'(pwrite), 32'(tbl[i].exp_psel));
         chk($sformatf("v%0d.busy", i), 32'(busy), 32'(tbl[i].exp_psel));
         chk($sformatf("v%0d.paddr", i), paddr, tbl[i].exp_paddr);
         chk($sformatf("v%0d.pwdata", i), pwdata, tbl[i].exp_pwdata);
         chk($sformatf("v%0d.err", i), 32'(err_cnt), 32'(tbl[i].exp_err));
         step();
      end

      // Reset in the middle of a stalled ACCESS abandons the transfer.
      req_valid = 4'b0100; pready = 1'b1; pslverr = 1'b0;
      step();
      req_valid = 4'b0000;
      step();
      pready = 1'b0; rst_ni = 1'b0;
      @(negedge clk);
      chk("rsta.penable_before", 32'(penable), 32'h1);
      chk("rsta.ready_in_reset", 32'(req_ready), 32'h0);
      step();
      rst_ni = 1'b1; pready = 1'b1; req_valid = 4'b1111;
      @(negedge clk);
      chk("rsta.psel", 32'(psel), 32'h0);
      chk("rsta.busy", 32'(busy), 32'h0);
      chk("rsta.ready_ptr0", 32'(req_ready), 32'h1);
      chk("rsta.err", 32'(err_cnt), 32'h0);
      step();
      req_valid = 4'b0000;
      step();
      step();

      // Saturation: start the error counter just below its ceiling.
      force dut.err_cnt_q = 16'hFFFD;
      #1;
      release dut.err_cnt_q;
      for (int k = 0; k < 3; k++) begin
         req_valid = 4'b0001; pslverr = 1'b0;
         step();
         req_valid = 4'b0000;
         step();
         pslverr = 1'b1;
         step();
         pslverr = 1'b0;
         @(negedge clk);
         chk($sformatf("sat%0d.err", k), 32'(err_cnt), (k == 0) ? 32'hFFFE : 32'hFFFF);
      end

      // Randomized traffic against the model.
      rst_ni = 1'b0;
      step();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int          g;
         logic [3:0]  exp_ready;
         rst_ni = ($urandom_range(0, 499) != 0);
         for (int r = 0; r < N; r++) req_valid[r] = ($urandom_range(0, 3) != 0);
         pready   = ($urandom_range(0, 2) != 0);
         pslverr  = ($urandom_range(0, 3) == 0);
         req_cl   = $urandom;
         req_core = $urandom;
         req_char = $urandom;
         g = (rst_ni && (!m_act || (m_acc && pready))) ? pick(req_valid, m_ptr) : -1;
         exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
         @(negedge clk);
         chk("rnd.ready", 32'(req_ready), 32'(exp_ready));
         chk("rnd.psel", 32'(psel), 32'(m_act));
         chk("rnd.penable", 32'(penable), 32'(m_act && m_acc));
         chk("rnd.paddr", paddr, m_paddr);
         chk("rnd.pwdata", pwdata, m_pwdata);
         chk("rnd.err", 32'(err_cnt), 32'(m_err));
         @(posedge clk);
         if (!rst_ni) begin
            model_reset();
         end else begin
            if (m_act && m_acc && pready) begin
               if (pslverr && m_err < 65535) m_err++;
               m_act = 1'b0;
            end else if (m_act) begin
               m_acc = 1'b1;
            end
            if (g >= 0) begin
               m_act    = 1'b1;
               m_acc    = 1'b0;
               m_paddr  = BASE | (32'(req_cl[g*4 +: 4]) * 128) | (32'(req_core[g*4 +: 4]) * 8);
               m_pwdata = 32'(req_char[g*8 +: 8]);
               m_ptr    = (g + 1) % N;
            end
         end
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
